// File: rtl/fadd_share_sched.sv
// Round-robin scheduler sharing one pipelined FP adder among requesters.
// Optional counters stat_issued/stat_stall: define FADD_SCHED_STATS_EN.
module fadd_share_sched #(
  parameter logic [1:0] S         = 2'b00,
  parameter int         NUM_REQ   = 4,
  parameter int         ADD_LAT   = 5,
  parameter int         RSP_DEPTH = 8,
  localparam int W   = (S == 2'b00) ? 16 :
                       (S == 2'b01) ? 32 : 64,
  localparam int IDW = (NUM_REQ > 2) ?
                       $clog2(NUM_REQ) : 1
) (
  input  logic                 clk_44,
  input  logic                 reset_44,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [W-1:0]         add_in1,
  output logic [W-1:0]         add_in2,
  input  logic [W-1:0]         add_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic                 busy
`ifdef FADD_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stall
`endif
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  credit_q, credit_d;
  logic [W-1:0]   in1_q, in1_d;
  logic [W-1:0]   in2_q, in2_d;

  logic [ADD_LAT:0] tv_q;
  logic [IDW-1:0]   tid_q [ADD_LAT+1];

  logic [IDW-1:0] mem_id_q  [RSP_DEPTH];
  logic [W-1:0]   mem_dat_q [RSP_DEPTH];
  logic [PW-1:0]  wp_q, wp_d;
  logic [PW-1:0]  rp_q, rp_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           gnt_ok;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand;
  logic           issue;
  logic           pop;
  logic           fifo_wr;

  // first valid requester at or after the pointer, wrapping
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ))
        cand = cand - (IDW+1)'(NUM_REQ);
      if (!gnt_ok && req_valid[cand[IDW-1:0]]) begin
        gnt_ok  = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
    if (credit_q == '0 || !reset_44)
      gnt_ok = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (gnt_ok)
      req_ready[gnt_idx] = 1'b1;
  end

  assign issue   = |(req_valid & req_ready);
  assign pop     = rsp_valid & rsp_ready;
  assign fifo_wr = tv_q[ADD_LAT];

  always_comb begin
    in1_d    = in1_q;
    in2_d    = in2_q;
    ptr_d    = ptr_q;
    credit_d = credit_q - CW'(issue) + CW'(pop);
    if (issue) begin
      in1_d = req_a[gnt_idx*W +: W];
      in2_d = req_b[gnt_idx*W +: W];
      if (gnt_idx == IDW'(NUM_REQ - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_44 or negedge reset_44) begin
    if (!reset_44) begin
      ptr_q    <= '0;
      credit_q <= CW'(RSP_DEPTH);
      in1_q    <= '0;
      in2_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
    end
  end

  assign add_in1 = in1_q;
  assign add_in2 = in2_q;

  // slot 0 rides with the operand register, slots 1..ADD_LAT with the adder
  always_ff @(posedge clk_44 or negedge reset_44) begin
    if (!reset_44) begin
      tv_q <= '0;
      for (int i = 0; i <= ADD_LAT; i++)
        tid_q[i] <= '0;
    end else begin
      tv_q     <= {tv_q[ADD_LAT-1:0], issue};
      tid_q[0] <= gnt_idx;
      for (int i = 1; i <= ADD_LAT; i++)
        tid_q[i] <= tid_q[i-1];
    end
  end

  always_comb begin
    wp_d  = wp_q + PW'(fifo_wr);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + CW'(fifo_wr) - CW'(pop);
  end

  always_ff @(posedge clk_44 or negedge reset_44) begin
    if (!reset_44) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_44) begin
    if (fifo_wr) begin
      mem_id_q[wp_q]  <= tid_q[ADD_LAT];
      mem_dat_q[wp_q] <= add_out;
    end
  end

  assign rsp_valid = (cnt_q != '0);
  assign rsp_id    = rsp_valid ? mem_id_q[rp_q]  : '0;
  assign rsp_data  = rsp_valid ? mem_dat_q[rp_q] : '0;
  assign busy      = (|tv_q) | rsp_valid;

`ifdef FADD_SCHED_STATS_EN
  logic [31:0] iss_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_44 or negedge reset_44) begin
    if (!reset_44) begin
      iss_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue)
        iss_cnt_q <= iss_cnt_q + 32'd1;
      if ((|req_valid) && credit_q == '0)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_issued = iss_cnt_q;
  assign stat_stall  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fadd_share_sched.sv
// Bench for fadd_share_sched: directed scenarios plus a queue-based
// reference model of grants, credits and in-order tagged responses.
module tb_fadd_share_sched;
  localparam logic [1:0] S = 2'b00;
  localparam int N   = 4;
  localparam int LAT = 5;
  localparam int D   = 8;
  localparam int W   = 16;
  localparam int IDW = 2;

  logic           clk_44   = 1'b0;
  logic           reset_44 = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [W-1:0]   add_in1, add_in2, add_out;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;
`ifdef FADD_SCHED_STATS_EN
  logic [31:0]    stat_issued, stat_stall;
`endif

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;

  fadd_share_sched #(
    .S(S), .NUM_REQ(N), .ADD_LAT(LAT), .RSP_DEPTH(D)
  ) dut (
    .clk_44(clk_44), .reset_44(reset_44),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_in1(add_in1), .add_in2(add_in2),
    .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
`ifdef FADD_SCHED_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk_44 = ~clk_44;
  always @(posedge clk_44) cyc <= cyc + 1;

  // adder stand-in: known half-precision sums, otherwise integer add
  function automatic logic [W-1:0] fadd_ref(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0] k;
    k = {a, b};
    case (k)
      32'h2E66_B800: return 16'hB666;
      32'hCB80_4200: return 16'hCA00;
      32'h4E46_4300: return 16'h4F26;
      default:       return a + b;
    endcase
  endfunction

  logic [W-1:0] apipe [LAT];
  always @(posedge clk_44) begin
    apipe[0] <= fadd_ref(add_in1, add_in2);
    for (int i = 1; i < LAT; i++)
      apipe[i] <= apipe[i-1];
  end
  assign add_out = apipe[LAT-1];

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    int             vis;
  } exp_t;

  exp_t q[$];
  int   m_ptr    = 0;
  int   m_issued = 0;
  int   m_stall  = 0;

  // reference model: every entry accepted but not yet popped lives in q
  always @(negedge clk_44) begin
    int           g;
    bit           ok;
    bit           erv;
    logic [N-1:0] er;
    if (!reset_44) begin
      q.delete();
      m_ptr    = 0;
      m_issued = 0;
      m_stall  = 0;
    end else begin
      ok = 0;
      g  = 0;
      er = '0;
      if (q.size() < D)
        for (int k = 0; k < N; k++)
          if (!ok && req_valid[(m_ptr + k) % N]) begin
            ok = 1;
            g  = (m_ptr + k) % N;
          end
      if (ok) er[g] = 1'b1;
      nchk++;
      if (req_ready !== er) begin
        nfail++;
        $display("FAIL grant cyc=%0d got %b want %b", cyc, req_ready, er);
      end
      erv = (q.size() != 0) && (q[0].vis <= cyc);
      nchk++;
      if (rsp_valid !== erv) begin
        nfail++;
        $display("FAIL rsp_valid cyc=%0d got %b want %b", cyc, rsp_valid, erv);
      end
      if (erv) begin
        nchk++;
        if (rsp_id !== q[0].id || rsp_data !== q[0].sum) begin
          nfail++;
          $display("FAIL rsp_head cyc=%0d got %0d/%h want %0d/%h",
                   cyc, rsp_id, rsp_data, q[0].id, q[0].sum);
        end
      end
      nchk++;
      if (busy !== (q.size() != 0)) begin
        nfail++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, q.size() != 0);
      end
      nchk++;
      if (dut.fifo_wr && dut.cnt_q == D) begin
        nfail++;
        $display("FAIL overflow cyc=%0d write with occupancy %0d want <%0d",
                 cyc, dut.cnt_q, D);
      end
`ifdef FADD_SCHED_STATS_EN
      nchk++;
      if (stat_issued !== 32'(m_issued) || stat_stall !== 32'(m_stall)) begin
        nfail++;
        $display("FAIL stats cyc=%0d got %0d/%0d want %0d/%0d",
                 cyc, stat_issued, stat_stall, m_issued, m_stall);
      end
`endif
      if ((|req_valid) && q.size() >= D) m_stall++;
      if (erv && rsp_ready) void'(q.pop_front());
      if (ok) begin
        q.push_back('{id: IDW'(g),
                      sum: fadd_ref(req_a[g*W +: W], req_b[g*W +: W]),
                      vis: cyc + LAT + 2});
        m_issued++;
        m_ptr = (g + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk_44);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    reset_44  = 1'b0;
    repeat (2) tick();
    reset_44  = 1'b1;
    tick();
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2 * (LAT + D + 4)) tick();
    rsp_ready = 1'b0;
  endtask

  task automatic issue_one(input int r);
    req_a[r*W +: W] = W'($urandom);
    req_b[r*W +: W] = W'($urandom);
    req_valid = '0;
    req_valid[r] = 1'b1;
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset();
    req_valid = '1;
    reset_44  = 1'b0;
    repeat (2) tick();
    nchk++;
    if (req_ready !== '0 || add_in1 !== '0 || add_in2 !== '0) begin
      nfail++;
      $display("FAIL reset_issue got %b/%h/%h want 0", req_ready, add_in1, add_in2);
    end
    nchk++;
    if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_rsp got %b/%0d/%h/%b want 0", rsp_valid, rsp_id, rsp_data, busy);
    end
    req_valid = '0;
    reset_44  = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    rsp_ready = 1'b1;
    req_a[0 +: W] = 16'h2E66;
    req_b[0 +: W] = 16'hB800;
    req_valid = 4'b0001;
    @(negedge clk_44);
    nchk++;
    if (req_ready !== 4'b0001) begin
      nfail++;
      $display("FAIL single_ready got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    nchk++;
    if (n != LAT + 1) begin
      nfail++;
      $display("FAIL single_latency got %0d want %0d", n, LAT + 1);
    end
    nchk++;
    if (rsp_id !== 2'd0 || rsp_data !== 16'hB666) begin
      nfail++;
      $display("FAIL single_data got %0d/%h want 0/b666", rsp_id, rsp_data);
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    int npop;
    apply_reset();
    rsp_ready = 1'b1;
    npop = 0;
    for (int i = 0; i < 12 + LAT + 6; i++) begin
      if (i < 12) begin
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_valid = '1;
      end else begin
        req_valid = '0;
      end
      @(negedge clk_44);
      if (i < 12) begin
        e = '0;
        e[i % N] = 1'b1;
        nchk++;
        if (req_ready !== e) begin
          nfail++;
          $display("FAIL rr_grant step=%0d got %b want %b", i, req_ready, e);
        end
      end
      if (rsp_valid) begin
        nchk++;
        if (rsp_id !== IDW'(npop % N)) begin
          nfail++;
          $display("FAIL rr_order pop=%0d got %0d want %0d", npop, rsp_id, npop % N);
        end
        npop++;
      end
      tick();
    end
    nchk++;
    if (npop != 12) begin
      nfail++;
      $display("FAIL rr_count got %0d want 12", npop);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc;
`ifdef FADD_SCHED_STATS_EN
    logic [31:0] s0;
`endif
    rsp_ready = 1'b0;
    req_a[2*W +: W] = W'($urandom);
    req_b[2*W +: W] = W'($urandom);
    req_valid = 4'b0100;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_44);
      if (|(req_valid & req_ready)) acc++;
      tick();
    end
    nchk++;
    if (acc != D) begin
      nfail++;
      $display("FAIL bp_accepts got %0d want %0d", acc, D);
    end
    @(negedge clk_44);
    nchk++;
    if (req_ready !== '0) begin
      nfail++;
      $display("FAIL bp_ready got %b want 0000", req_ready);
    end
`ifdef FADD_SCHED_STATS_EN
    s0 = stat_stall;
    tick();
    @(negedge clk_44);
    nchk++;
    if (stat_stall !== s0 + 32'd1) begin
      nfail++;
      $display("FAIL bp_stall got %0d want %0d", stat_stall, s0 + 32'd1);
    end
`endif
    tick();
    acc = 0;
    for (int i = 0; i < 11; i++) begin
      rsp_ready = (i == 0);
      @(negedge clk_44);
      if (|(req_valid & req_ready)) acc++;
      tick();
    end
    nchk++;
    if (acc != 1) begin
      nfail++;
      $display("FAIL bp_one_more got %0d want 1", acc);
    end
    drain();
  endtask

  task automatic test_pair();
    apply_reset();
    rsp_ready = 1'b0;
    req_a[1*W +: W] = 16'hCB80;
    req_b[1*W +: W] = 16'h4200;
    req_a[3*W +: W] = 16'h4E46;
    req_b[3*W +: W] = 16'h4300;
    req_valid = 4'b1010;
    @(negedge clk_44);
    nchk++;
    if (req_ready !== 4'b0010) begin
      nfail++;
      $display("FAIL pair_first got %b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b1000;
    @(negedge clk_44);
    nchk++;
    if (req_ready !== 4'b1000) begin
      nfail++;
      $display("FAIL pair_second got %b want 1000", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (LAT + 1) tick();
    nchk++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'hCA00) begin
      nfail++;
      $display("FAIL pair_rsp1 got %b/%0d/%h want 1/1/ca00", rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    nchk++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'h4F26) begin
      nfail++;
      $display("FAIL pair_rsp2 got %b/%0d/%h want 1/3/4f26", rsp_valid, rsp_id, rsp_data);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int acc;
    int r;
    rsp_ready = 1'b0;
    repeat (2) issue_one(int'($urandom_range(0, N - 1)));
    repeat (LAT + 2) tick();
    repeat (3) issue_one(int'($urandom_range(0, N - 1)));
    nchk++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1) begin
      nfail++;
      $display("FAIL mid_pre got %b/%b want 1/1", busy, rsp_valid);
    end
    reset_44 = 1'b0;
    #1;
    nchk++;
    if (req_ready !== '0 || add_in1 !== '0 || add_in2 !== '0 ||
        rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL mid_reset got %b/%h/%h/%b/%0d/%h/%b want 0",
               req_ready, add_in1, add_in2, rsp_valid, rsp_id, rsp_data, busy);
    end
    tick();
    reset_44 = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk_44);
      nchk++;
      if (rsp_valid !== 1'b0) begin
        nfail++;
        $display("FAIL mid_stale step=%0d got %b want 0", i, rsp_valid);
      end
      tick();
    end
    rsp_ready = 1'b0;
    r = int'($urandom_range(0, N - 1));
    req_valid = '0;
    req_valid[r] = 1'b1;
    acc = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_44);
      if (|(req_valid & req_ready)) acc++;
      tick();
    end
    nchk++;
    if (acc != D) begin
      nfail++;
      $display("FAIL mid_credit got %0d want %0d", acc, D);
    end
    drain();
  endtask

  task automatic test_fifo_simul();
    int cnt;
    rsp_ready = 1'b0;
    repeat (D - 1) issue_one(int'($urandom_range(0, N - 1)));
    repeat (LAT + 2) tick();
    issue_one(int'($urandom_range(0, N - 1)));
    repeat (LAT) tick();
    rsp_ready = 1'b1;
    @(negedge clk_44);
    nchk++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL simul_head got %b/%b want 1/1", rsp_valid, busy);
    end
    tick();
    rsp_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_44);
      if (rsp_valid) cnt++;
      tick();
    end
    nchk++;
    if (cnt != D - 1) begin
      nfail++;
      $display("FAIL simul_occupancy got %0d want %0d", cnt, D - 1);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      if (i < 200) rsp_ready = ($urandom_range(0, 3) != 0);
      else         rsp_ready = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pair();
    test_reset_midflight();
    test_fifo_simul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
